mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 37 +++
 rtl/mem_access_load_align.sv | 34 +++
 rtl/mem_access.sv | 186 ++++++++++++++++++
 tb/tb_mem_access.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_pkg
// Brief   : Shared opcode/funct3 constants, FSM state type and an alignment
//           helper for the memory-access stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Size is encoded in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    case (f3[1:0])
      2'b01:   r = lo[0];
      2'b10:   r = (lo != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// ============================================================================
// Module  : load_align
// Brief   : Selects the addressed lane of a read word and sign/zero-extends it
//           according to the load funct3.
// Revision: 1.0 - initial release
// ============================================================================
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr, 3'b000};

  // Lane select and extension by access size and signedness.
  always_comb begin
    o_result = i_rdata;
    case (i_funct3)
      F3_B:    o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_result = {24'h000000, w_shifted[7:0]};
      F3_HU:   o_result = {16'h0000, w_shifted[15:0]};
      default: o_result = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module  : mem_access
// Brief   : Memory stage: pass-through of non-memory results, aligned load /
//           store issue to a req/ack data bus with timeout, misalignment and
//           bus-error reporting on a one-cycle writeback pulse.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_exc_misaligned,
  output logic        o_exc_bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dmem_we;
  logic [31:0]   r_dmem_addr;
  logic [31:0]   r_dmem_wdata;
  logic [3:0]    r_dmem_wstrb;
  logic [1:0]    r_addr_lo;
  logic [2:0]    r_funct3;
  logic          r_wb_valid;
  logic          r_wb_we;
  logic [4:0]    r_wb_rd;
  logic [31:0]   r_wb_data;
  logic          r_exc_mis;
  logic          r_exc_bus;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_misaligned;
  logic        w_accept;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];

  // Undefined funct3 values fall out of both classes and become pass-through.
  assign w_is_load  = (w_opcode == OP_LOAD) &&
                      (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W ||
                       w_funct3 == F3_BU || w_funct3 == F3_HU);
  assign w_is_store = (w_opcode == OP_STORE) &&
                      (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W);
  assign w_misaligned = (w_is_load || w_is_store) &&
                        is_misaligned(w_funct3, i_alu_result[1:0]);
  assign w_accept = i_in_valid && (r_state == IDLE);

  // Store lane replication and byte strobes; loads never write.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = i_store_data;
    if (w_is_store) begin
      case (w_funct3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << i_alu_result[1:0];
          w_wdata = {4{i_store_data[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << i_alu_result[1:0];
          w_wdata = {2{i_store_data[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = i_store_data;
        end
      endcase
    end
  end

  load_align u_load_align (
    .i_rdata  (i_dmem_rdata),
    .i_addr   (r_addr_lo),
    .i_funct3 (r_funct3),
    .o_result (w_load_data)
  );

  // Control FSM; writeback fields are single-cycle and default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'h0;
      r_dmem_wdata <= 32'h0;
      r_dmem_wstrb <= 4'h0;
      r_addr_lo    <= 2'b00;
      r_funct3     <= 3'b000;
      r_wb_valid   <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_data    <= 32'h0;
      r_exc_mis    <= 1'b0;
      r_exc_bus    <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_exc_mis  <= 1'b0;
      r_exc_bus  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wb_rd <= w_rd;
            if ((w_is_load || w_is_store) && !w_misaligned) begin
              r_state      <= BUSY;
              r_cnt        <= '0;
              r_dmem_we    <= w_is_store;
              r_dmem_addr  <= {i_alu_result[31:2], 2'b00};
              r_dmem_wdata <= w_wdata;
              r_dmem_wstrb <= w_wstrb;
              r_addr_lo    <= i_alu_result[1:0];
              r_funct3     <= w_funct3;
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= i_alu_result;
              r_exc_mis  <= w_misaligned;
              r_wb_we    <= (w_opcode != OP_LOAD) && (w_opcode != OP_STORE) &&
                            (w_rd != 5'd0);
            end
          end
        end
        BUSY: begin
          if (i_dmem_ack) begin
            r_state    <= IDLE;
            r_wb_valid <= 1'b1;
            r_wb_we    <= !r_dmem_we && (r_wb_rd != 5'd0);
            r_wb_data  <= r_dmem_we ? 32'h0 : w_load_data;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wb_valid <= 1'b1;
            r_exc_bus  <= 1'b1;
            r_wb_data  <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready       = (r_state == IDLE);
  assign o_dmem_req       = (r_state == BUSY);
  assign o_dmem_we        = r_dmem_we;
  assign o_dmem_addr      = r_dmem_addr;
  assign o_dmem_wdata     = r_dmem_wdata;
  assign o_dmem_wstrb     = r_dmem_wstrb;
  assign o_wb_valid       = r_wb_valid;
  assign o_wb_we          = r_wb_we;
  assign o_wb_rd          = r_wb_rd;
  assign o_wb_data        = r_wb_data;
  assign o_exc_misaligned = r_exc_mis;
  assign o_exc_bus_err    = r_exc_bus;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access
// Brief   : Self-checking bench for mem_access with a writeback scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [31:0] i_instr = 32'h0;
  logic [31:0] i_alu_result = 32'h0;
  logic [31:0] i_store_data = 32'h0;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic        i_dmem_ack = 1'b0;
  logic [31:0] i_dmem_rdata = 32'h0;
  logic        o_wb_valid;
  logic        o_wb_we;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_exc_misaligned;
  logic        o_exc_bus_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        bus;
    logic        chk_rd_data;
  } wb_t;

  wb_t q[$];

  mem_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_in_valid       (i_in_valid),
    .o_in_ready       (o_in_ready),
    .i_instr          (i_instr),
    .i_alu_result     (i_alu_result),
    .i_store_data     (i_store_data),
    .o_dmem_req       (o_dmem_req),
    .o_dmem_we        (o_dmem_we),
    .o_dmem_addr      (o_dmem_addr),
    .o_dmem_wdata     (o_dmem_wdata),
    .o_dmem_wstrb     (o_dmem_wstrb),
    .i_dmem_ack       (i_dmem_ack),
    .i_dmem_rdata     (i_dmem_rdata),
    .o_wb_valid       (o_wb_valid),
    .o_wb_we          (o_wb_we),
    .o_wb_rd          (o_wb_rd),
    .o_wb_data        (o_wb_data),
    .o_exc_misaligned (o_exc_misaligned),
    .o_exc_bus_err    (o_exc_bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'h0, f3, rd, op};
  endfunction

  function automatic wb_t exp_wb(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                 input logic mis, input logic bus, input logic chk);
    wb_t e;
    e.we = we; e.rd = rd; e.data = data; e.mis = mis; e.bus = bus; e.chk_rd_data = chk;
    return e;
  endfunction

  // Scoreboard: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && o_wb_valid) begin
      wb_t e;
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h, required no writeback", o_wb_rd, o_wb_data);
      end else begin
        e = q.pop_front();
        if (o_wb_we !== e.we || o_exc_misaligned !== e.mis || o_exc_bus_err !== e.bus ||
            (e.chk_rd_data && (o_wb_rd !== e.rd || o_wb_data !== e.data)))
          $display("FAIL wb_result: got we=%b rd=%0d data=%h mis=%b bus=%b, required we=%b rd=%0d data=%h mis=%b bus=%b",
                   o_wb_we, o_wb_rd, o_wb_data, o_exc_misaligned, o_exc_bus_err,
                   e.we, e.rd, e.data, e.mis, e.bus);
        else
          n_pass++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] sd);
    i_in_valid   = 1'b1;
    i_instr      = ins;
    i_alu_result = alu;
    i_store_data = sd;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  // Ack arrives during BUSY cycle k (cycle 1 is the one right after accept).
  task automatic ack_in_cycle(input int k, input logic [31:0] rdata);
    step(k - 1);
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = rdata;
    @(posedge clk);
    #1;
    i_dmem_ack = 1'b0;
  endtask

  task automatic check_drained(input string name);
    step(1);
    n_total++;
    if (q.size() != 0) $display("FAIL %s_drained: %0d writebacks still pending, required 0", name, q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    n_total++;
    if ({o_in_ready, o_dmem_req, o_dmem_we, o_wb_valid, o_wb_we, o_exc_misaligned, o_exc_bus_err} !== 7'b1000000 ||
        o_dmem_addr !== 32'h0 || o_dmem_wdata !== 32'h0 || o_dmem_wstrb !== 4'h0 ||
        o_wb_rd !== 5'd0 || o_wb_data !== 32'h0)
      $display("FAIL reset_state: ready=%b req=%b addr=%h wb_valid=%b wb_data=%h, required ready=1 and all else 0",
               o_in_ready, o_dmem_req, o_dmem_addr, o_wb_valid, o_wb_data);
    else n_pass++;
  endtask

  task automatic test_passthrough;
    q.push_back(exp_wb(1'b1, 5'd3, 32'h0000_0055, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_ALU, 5'd3, 3'b000), 32'h0000_0055, 32'h0);
    n_total++;
    if (o_wb_valid !== 1'b1 || o_in_ready !== 1'b1) $display("FAIL pass_latency: wb_valid=%b ready=%b, required 1 1", o_wb_valid, o_in_ready);
    else n_pass++;
    step(1);
    q.push_back(exp_wb(1'b0, 5'd0, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_ALU, 5'd0, 3'b000), 32'hCAFE_0001, 32'h0);
    check_drained("passthrough");
  endtask

  task automatic test_back_to_back;
    q.push_back(exp_wb(1'b1, 5'd9, 32'h1111_1111, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_ALU, 5'd9, 3'b000), 32'h1111_1111, 32'h0);
    q.push_back(exp_wb(1'b0, 5'd4, 32'h0000_0101, 1'b1, 1'b0, 1'b0));
    drive(mk(OP_LD, 5'd4, 3'b010), 32'h0000_0101, 32'h0);
    q.push_back(exp_wb(1'b1, 5'd10, 32'h2222_2222, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_ALU, 5'd10, 3'b000), 32'h2222_2222, 32'h0);
    check_drained("back_to_back");
  endtask

  task automatic test_lw;
    q.push_back(exp_wb(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_LD, 5'd5, 3'b010), 32'h0000_0100, 32'h0);
    n_total++;
    if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h100 || o_dmem_we !== 1'b0 || o_dmem_wstrb !== 4'h0 || o_in_ready !== 1'b0)
      $display("FAIL lw_issue: req=%b addr=%h we=%b wstrb=%b ready=%b, required 1 00000100 0 0000 0",
               o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_wstrb, o_in_ready);
    else n_pass++;
    ack_in_cycle(3, 32'hDEAD_BEEF);
    n_total++;
    if (o_dmem_req !== 1'b0 || o_wb_valid !== 1'b1 || o_in_ready !== 1'b1)
      $display("FAIL lw_complete: req=%b wb_valid=%b ready=%b, required 0 1 1", o_dmem_req, o_wb_valid, o_in_ready);
    else n_pass++;
    check_drained("lw");
  endtask

  task automatic test_lb_lbu;
    q.push_back(exp_wb(1'b1, 5'd6, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_LD, 5'd6, 3'b000), 32'h0000_0103, 32'h0);
    n_total++;
    if (o_dmem_addr !== 32'h100) $display("FAIL lb_addr: got %h, required 00000100", o_dmem_addr);
    else n_pass++;
    ack_in_cycle(1, 32'h80FF_FFFF);
    q.push_back(exp_wb(1'b1, 5'd7, 32'h0000_0080, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_LD, 5'd7, 3'b100), 32'h0000_0103, 32'h0);
    ack_in_cycle(2, 32'h80FF_FFFF);
    q.push_back(exp_wb(1'b1, 5'd8, 32'hFFFF_8001, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_LD, 5'd8, 3'b001), 32'h0000_0202, 32'h0);
    ack_in_cycle(1, 32'h8001_1234);
    check_drained("lb_lbu");
  endtask

  task automatic test_stores;
    q.push_back(exp_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    drive(mk(OP_ST, 5'd2, 3'b001), 32'h0000_0102, 32'h1234_ABCD);
    n_total++;
    if (o_dmem_req !== 1'b1 || o_dmem_we !== 1'b1 || o_dmem_wstrb !== 4'b1100 ||
        o_dmem_wdata !== 32'hABCD_ABCD || o_dmem_addr !== 32'h100)
      $display("FAIL sh_issue: req=%b we=%b wstrb=%b wdata=%h addr=%h, required 1 1 1100 abcdabcd 00000100",
               o_dmem_req, o_dmem_we, o_dmem_wstrb, o_dmem_wdata, o_dmem_addr);
    else n_pass++;
    step(1);
    n_total++;
    if (o_dmem_wstrb !== 4'b1100 || o_dmem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_stable: wstrb=%b wdata=%h, required 1100 abcdabcd", o_dmem_wstrb, o_dmem_wdata);
    else n_pass++;
    ack_in_cycle(1, 32'h0);
    q.push_back(exp_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    drive(mk(OP_ST, 5'd1, 3'b000), 32'h0000_0101, 32'h0000_00EF);
    n_total++;
    if (o_dmem_wstrb !== 4'b0010 || o_dmem_wdata !== 32'hEFEF_EFEF) $display("FAIL sb_issue: wstrb=%b wdata=%h, required 0010 efefefef", o_dmem_wstrb, o_dmem_wdata);
    else n_pass++;
    ack_in_cycle(1, 32'h0);
    check_drained("stores");
  endtask

  task automatic test_misaligned;
    q.push_back(exp_wb(1'b0, 5'd5, 32'h0, 1'b1, 1'b0, 1'b0));
    drive(mk(OP_LD, 5'd5, 3'b010), 32'h0000_0101, 32'h0);
    n_total++;
    if (o_dmem_req !== 1'b0 || o_wb_valid !== 1'b1 || o_exc_misaligned !== 1'b1)
      $display("FAIL misaligned: req=%b wb_valid=%b mis=%b, required 0 1 1", o_dmem_req, o_wb_valid, o_exc_misaligned);
    else n_pass++;
    q.push_back(exp_wb(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0));
    drive(mk(OP_ST, 5'd0, 3'b001), 32'h0000_0203, 32'h0);
    n_total++;
    if (o_dmem_req !== 1'b0) $display("FAIL sh_misaligned_req: req=%b, required 0", o_dmem_req);
    else n_pass++;
    check_drained("misaligned");
  endtask

  task automatic test_undef_funct3;
    q.push_back(exp_wb(1'b0, 5'd7, 32'h0000_0044, 1'b0, 1'b0, 1'b1));
    drive(mk(OP_LD, 5'd7, 3'b011), 32'h0000_0044, 32'h0);
    n_total++;
    if (o_dmem_req !== 1'b0 || o_in_ready !== 1'b1) $display("FAIL undef_req: req=%b ready=%b, required 0 1", o_dmem_req, o_in_ready);
    else n_pass++;
    check_drained("undef_funct3");
  endtask

  task automatic test_timeout;
    int cnt;
    q.push_back(exp_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0));
    drive(mk(OP_ST, 5'd0, 3'b010), 32'h0000_0400, 32'h5555_AAAA);
    cnt = 0;
    while (o_dmem_req === 1'b1 && cnt < 40) begin
      cnt++;
      step(1);
    end
    n_total++;
    if (cnt != 16) $display("FAIL timeout_req_cycles: got %0d, required 16", cnt);
    else n_pass++;
    n_total++;
    if (o_wb_valid !== 1'b1 || o_exc_bus_err !== 1'b1) $display("FAIL timeout_pulse: wb_valid=%b bus_err=%b, required 1 1", o_wb_valid, o_exc_bus_err);
    else n_pass++;
    check_drained("timeout");
    q.push_back(exp_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    drive(mk(OP_ST, 5'd0, 3'b010), 32'h0000_0400, 32'h5555_AAAA);
    ack_in_cycle(16, 32'h0);
    n_total++;
    if (o_wb_valid !== 1'b1 || o_exc_bus_err !== 1'b0 || o_dmem_req !== 1'b0)
      $display("FAIL ack_at_limit: wb_valid=%b bus_err=%b req=%b, required 1 0 0", o_wb_valid, o_exc_bus_err, o_dmem_req);
    else n_pass++;
    check_drained("ack_at_limit");
  endtask

  task automatic test_idle_ack;
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h1234_5678;
    step(2);
    i_dmem_ack = 1'b0;
    n_total++;
    if (o_in_ready !== 1'b1 || o_dmem_req !== 1'b0 || o_wb_valid !== 1'b0)
      $display("FAIL idle_ack: ready=%b req=%b wb_valid=%b, required 1 0 0", o_in_ready, o_dmem_req, o_wb_valid);
    else n_pass++;
    check_drained("idle_ack");
  endtask

  task automatic test_reset_mid_busy;
    drive(mk(OP_LD, 5'd12, 3'b010), 32'h0000_0300, 32'h0);
    step(1);
    rst = 1'b1;
    #1;
    n_total++;
    if (o_dmem_req !== 1'b0 || o_wb_valid !== 1'b0 || o_dmem_addr !== 32'h0)
      $display("FAIL reset_mid_busy: req=%b wb_valid=%b addr=%h, required 0 0 00000000", o_dmem_req, o_wb_valid, o_dmem_addr);
    else n_pass++;
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    i_dmem_ack = 1'b0;
    n_total++;
    if (o_in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", o_in_ready);
    else n_pass++;
    step(3);
    n_total++;
    if (o_wb_valid !== 1'b0 || o_dmem_req !== 1'b0) $display("FAIL reset_abandon: wb_valid=%b req=%b, required 0 0", o_wb_valid, o_dmem_req);
    else n_pass++;
    check_drained("reset_mid_busy");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    step(2);
    test_reset;
    rst = 1'b0;
    step(1);
    test_passthrough;
    test_back_to_back;
    test_lw;
    test_lb_lbu;
    test_stores;
    test_misaligned;
    test_undef_funct3;
    test_timeout;
    test_idle_ack;
    test_reset_mid_busy;
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
